// File: rtl/serial_cmp_ctrl_if.sv
//------------------------------------------------------------------------------
// Module      : serial_cmp_ctrl_if
// Description : Operand/result bundle of the bit-serial comparator controller.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface serial_cmp_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] A_in;
    logic [WIDTH-1:0] B_in;
    logic             busy;
    logic             done;
    logic             res_valid;
    logic             res_le;
    logic             res_gt;
    logic             res_eq;

    modport master (
        output start, A_in, B_in,
        input  busy, done, res_valid, res_le, res_gt, res_eq
    );

    modport slave (
        input  start, A_in, B_in,
        output busy, done, res_valid, res_le, res_gt, res_eq
    );
endinterface

`default_nettype wire

// File: rtl/serial_cmp_ctrl.sv
//------------------------------------------------------------------------------
// Module      : serial_cmp_ctrl
// Description : Bit-serial LSB-first unsigned comparator (A<=B / A>B / A==B).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module serial_cmp_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    serial_cmp_ctrl_if.slave  cmp
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] c_last = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [WIDTH-1:0] r_sh_a;
    logic [WIDTH-1:0] r_sh_b;
    logic [CNT_W-1:0] r_cnt;
    logic             r_p;
    logic             r_e;
    logic             r_res_valid;
    logic             r_res_le;
    logic             r_res_eq;

    logic             w_capture;
    logic             w_step;
    logic             w_last;
    logic             w_busy;
    logic             w_done;
    logic             w_ai;
    logic             w_bi;
    logic             w_p_next;
    logic             w_e_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        w_step       = 1'b0;
        w_last       = 1'b0;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (cmp.start) begin
                    w_capture    = 1'b1;
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                w_busy = 1'b1;
                w_step = 1'b1;
                if (r_cnt == c_last) begin
                    w_last       = 1'b1;
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_busy       = 1'b1;
                w_done       = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Cell recurrence: a higher differing bit always overrides the carried state.
    assign w_ai     = r_sh_a[0];
    assign w_bi     = r_sh_b[0];
    assign w_p_next = r_p ? (w_ai <= w_bi) : (w_ai < w_bi);
    assign w_e_next = r_e & ~(w_ai ^ w_bi);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sh_a      <= '0;
            r_sh_b      <= '0;
            r_cnt       <= '0;
            r_p         <= 1'b1;
            r_e         <= 1'b1;
            r_res_valid <= 1'b0;
            r_res_le    <= 1'b0;
            r_res_eq    <= 1'b0;
        end else if (w_capture) begin
            r_sh_a      <= cmp.A_in;
            r_sh_b      <= cmp.B_in;
            r_cnt       <= '0;
            r_p         <= 1'b1;
            r_e         <= 1'b1;
            r_res_valid <= 1'b0;
        end else if (w_step) begin
            r_sh_a <= r_sh_a >> 1;
            r_sh_b <= r_sh_b >> 1;
            r_cnt  <= r_cnt + CNT_W'(1);
            r_p    <= w_p_next;
            r_e    <= w_e_next;
            if (w_last) begin
                r_res_valid <= 1'b1;
                r_res_le    <= w_p_next;
                r_res_eq    <= w_e_next;
            end
        end
    end

    assign cmp.busy      = w_busy;
    assign cmp.done      = w_done;
    assign cmp.res_valid = r_res_valid;
    assign cmp.res_le    = r_res_le;
    // Forced low while invalid so a stale result never reads as A>B.
    assign cmp.res_gt    = r_res_valid & ~r_res_le;
    assign cmp.res_eq    = r_res_eq;

endmodule

`default_nettype wire

// File: tb/tb_serial_cmp_ctrl.sv
//------------------------------------------------------------------------------
// Module      : tb_serial_cmp_ctrl
// Description : Self-checking bench for serial_cmp_ctrl (WIDTH=8 and WIDTH=1).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_serial_cmp_ctrl;

    localparam int W = 8;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    serial_cmp_ctrl_if #(.WIDTH(W)) b8 ();
    serial_cmp_ctrl_if #(.WIDTH(1)) b1 ();

    serial_cmp_ctrl #(.WIDTH(W)) u8 (.clk(clk), .reset(reset), .cmp(b8));
    serial_cmp_ctrl #(.WIDTH(1)) u1 (.clk(clk), .reset(reset), .cmp(b1));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: plain unsigned comparison of the captured operands.
    task automatic check_result(input string tag, input int a, input int b,
                                input logic valid, input logic le, input logic gt, input logic eq);
        check({tag, "_valid"}, valid, 1'b1);
        check({tag, "_le"}, le, (a <= b));
        check({tag, "_gt"}, gt, (a > b));
        check({tag, "_eq"}, eq, (a == b));
    endtask

    task automatic run8(input logic [W-1:0] a, input logic [W-1:0] b, input bit glitch);
        int  lat;
        bit  seen;
        @(posedge clk); #1;
        b8.start = 1'b1; b8.A_in = a; b8.B_in = b;
        @(posedge clk); #1;
        b8.start = 1'b0;
        lat  = 0;
        seen = 0;
        for (int c = 0; c < W + 6; c++) begin
            @(negedge clk);
            if (b8.done) begin
                seen = 1;
                break;
            end
            check("busy_run", b8.busy, 1'b1);
            if (c == 0) check("valid_clr", b8.res_valid, 1'b0);
            @(posedge clk); #1;
            if (glitch) begin
                b8.start = 1'($urandom_range(1));
                b8.A_in  = W'($urandom);
                b8.B_in  = W'($urandom);
            end
            lat++;
        end
        check("done_seen", seen, 1'b1);
        check("latency", lat, W);
        check("busy_done", b8.busy, 1'b1);
        b8.start = 1'b0;
        check_result("res", a, b, b8.res_valid, b8.res_le, b8.res_gt, b8.res_eq);
        @(negedge clk);
        check("done_pulse", b8.done, 1'b0);
        check("busy_idle", b8.busy, 1'b0);
        check_result("hold", a, b, b8.res_valid, b8.res_le, b8.res_gt, b8.res_eq);
    endtask

    task automatic run1(input logic a, input logic b);
        @(posedge clk); #1;
        b1.start = 1'b1; b1.A_in = a; b1.B_in = b;
        @(posedge clk); #1;
        b1.start = 1'b0;
        @(negedge clk);
        check("w1_done_early", b1.done, 1'b0);
        check("w1_busy_run", b1.busy, 1'b1);
        @(negedge clk);
        check("w1_done", b1.done, 1'b1);
        check_result("w1", int'(a), int'(b), b1.res_valid, b1.res_le, b1.res_gt, b1.res_eq);
    endtask

    initial begin
        int  m;
        logic [W-1:0] a, b;
        reset = 1'b1;
        b8.start = 1'b0; b8.A_in = '0; b8.B_in = '0;
        b1.start = 1'b0; b1.A_in = '0; b1.B_in = '0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_busy", b8.busy, 1'b0);
        check("rst_done", b8.done, 1'b0);
        check("rst_valid", b8.res_valid, 1'b0);
        check("rst_res", {b8.res_le, b8.res_gt, b8.res_eq}, 3'b000);
        @(posedge clk); #1;
        reset = 1'b0;

        run8(8'h35, 8'h35, 0);
        run8(8'h80, 8'h7F, 0);
        run8(8'h00, 8'h00, 0);
        run8(8'hFF, 8'hFF, 0);
        run8(8'h00, 8'hFF, 0);

        // Back-to-back with start held high: second done WIDTH+2 cycles later.
        @(posedge clk); #1;
        b8.start = 1'b1; b8.A_in = 8'h01; b8.B_in = 8'h02;
        m = 0;
        while (!b8.done && m < 40) begin
            @(negedge clk);
            m++;
        end
        check("b2b_first_done", b8.done, 1'b1);
        check_result("b2b1", 8'h01, 8'h02, b8.res_valid, b8.res_le, b8.res_gt, b8.res_eq);
        b8.A_in = 8'hFF; b8.B_in = 8'h00;
        m = 0;
        do begin
            @(negedge clk);
            m++;
        end while (!b8.done && m < 40);
        check("b2b_period", m, W + 2);
        check_result("b2b2", 8'hFF, 8'h00, b8.res_valid, b8.res_le, b8.res_gt, b8.res_eq);
        b8.start = 1'b0;
        @(negedge clk);
        check("b2b_idle", b8.busy, 1'b0);

        // Reset in the middle of a run aborts it without a done pulse.
        @(posedge clk); #1;
        b8.start = 1'b1; b8.A_in = 8'h12; b8.B_in = 8'h34;
        @(posedge clk); #1;
        b8.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check("abort_busy_pre", b8.busy, 1'b1);
        @(negedge clk);
        check("abort_busy", b8.busy, 1'b0);
        check("abort_valid", b8.res_valid, 1'b0);
        check("abort_res", {b8.res_le, b8.res_gt, b8.res_eq}, 3'b000);
        @(posedge clk); #1;
        reset = 1'b0;
        m = 0;
        for (int c = 0; c < W + 4; c++) begin
            @(negedge clk);
            if (b8.done) m++;
        end
        check("abort_no_done", m, 0);
        run8(8'h12, 8'h34, 0);

        // Randomized operands; half the runs toggle start/A_in/B_in while busy.
        for (int i = 0; i < 24; i++) begin
            a = W'($urandom);
            case ($urandom_range(3))
                0:       b = a;
                1:       b = a ^ W'(1 << $urandom_range(W - 1));
                default: b = W'($urandom);
            endcase
            run8(a, b, bit'(i % 2));
        end

        run1(1'b1, 1'b0);
        run1(1'b0, 1'b0);
        run1(1'b0, 1'b1);
        run1(1'b1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout got=0 exp=1");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/serial_cmp_ctrl.md
Name: serial_cmp_ctrl

Overview:
- Sequencing controller for the right-to-left iterative comparator cell (state a=1 "A<=B so far", b=0 "A>B so far").
- Captures two WIDTH-bit words on a start handshake, then feeds one bit pair per clock, LSB first, through a single cell-equivalent next-state function. It holds the carried state in a register between iterations.
- When the last bit is processed, it publishes the registered comparison result.
- Sits between an operand source and any consumer needing an A<=B / A>B / A==B decision from a bit-serial datapath.

Parameters:
- WIDTH, 8, operand width in bits; legal range 1..32.
- CNT_W, derived as clog2(WIDTH), minimum 1; width of the bit-index counter. Not user-overridden.

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, synchronous active-high reset.
- start, input, 1, request to compare A_in/B_in; sampled only in IDLE.
- A_in, input, WIDTH, operand A; captured when start is accepted.
- B_in, input, WIDTH, operand B; captured when start is accepted.
- busy, output, 1, high in RUN and DONE states.
- done, output, 1, single-cycle pulse; result just became valid.
- res_valid, output, 1, result registers hold a completed comparison.
- res_le, output, 1, final cell state: 1 = A<=B.
- res_gt, output, 1, inverse of res_le when res_valid=1; 0 when res_valid=0.
- res_eq, output, 1, 1 = A==B.

Behaviour:
- Reset (sync, evaluated at clk edge, overrides everything):
  - state=IDLE, busy=0, done=0, res_valid=0, res_le=0, res_gt=0, res_eq=0.
  - Counter=0, carried state p=1, equality flag e=1, operand shift registers=0.
- FSM states: IDLE, RUN, DONE.
  - IDLE, start=1: capture A_in/B_in into shift registers, count=0, p=1 (a), e=1, res_valid=0, go to RUN.
  - IDLE, start=0: stay in IDLE; results hold.
  - RUN: each cycle processes bit pair (Ai,Bi) = (shiftA[0], shiftB[0]).
    - p==1: p <= (Ai<=Bi) ? 1 : 0.
    - p==0: p <= (Ai<Bi) ? 1 : 0.
    - e <= e & ~(Ai^Bi).
    - Shift both registers right by 1; count++.
  - RUN, on the cycle processing bit WIDTH-1 (count==WIDTH-1): go to DONE. In the same edge, res_le <= next p, res_gt <= ~next p, res_eq <= next e, res_valid <= 1, done <= 1.
  - DONE: done=1 for exactly this one cycle, busy=1; go to IDLE unconditionally. start is ignored in DONE.
- Latency: start accepted at edge k; bit i is processed at edge k+1+i; done is high in the cycle following edge k+WIDTH. That is WIDTH+1 cycles from the start edge to the done pulse.
- Throughput: a new start is accepted no earlier than the edge after DONE. The minimum period is WIDTH+2 cycles.
- start held high continuously: a back-to-back comparison begins on the first IDLE edge after DONE.
- start while busy: ignored; no queuing, operands not recaptured.
- A_in/B_in changes after capture: no effect on the comparison in progress.
- res_* outputs hold their value in IDLE until the next accepted start. At that start, res_valid clears at the same edge; res_le/gt/eq may hold stale values but must be ignored while res_valid=0.
- WIDTH=1: RUN lasts one cycle; done appears 2 cycles after the start edge.
- Reset asserted during RUN or DONE: the comparison is aborted, the reset values above apply, and no done pulse is produced.
- Consistency invariants when res_valid=1:
  - res_eq=1 implies res_le=1.
  - res_gt = ~res_le.
- Arithmetic is unsigned. The LSB-first recurrence guarantees the final p reflects the most significant differing bit.

Test Plan:
- WIDTH=8, A=8'h35, B=8'h35, start pulse at edge 0 -> done high in cycle after edge 8; res_le=1, res_eq=1, res_gt=0, res_valid=1; busy high during cycles 1..9.
- A=8'h80, B=8'h7F -> res_gt=1, res_le=0, res_eq=0. The MSB dominates even though every lower bit has A<B.
- A=8'h01, B=8'h02 -> res_le=1, res_eq=0. Then, with start held high, A=8'hFF, B=8'h00 -> second done exactly WIDTH+2 cycles after the first; res_gt=1.
- start re-pulsed at cycle 3 of RUN with different A_in/B_in -> ignored; the result matches the originally captured operands and only one done pulse occurs.
- reset asserted at cycle 4 of RUN -> next edge: state IDLE, busy=0, res_valid=0, all res_*=0; no done pulse. A subsequent start completes normally.
- WIDTH=1 build: A=1, B=0 -> done 2 cycles after the start edge, res_gt=1. A=0, B=0 -> res_eq=1.
